nem_ohmux_sel_ctrl_4i: RTL and testbench
========================================

NEM_OHMUX_SEL_CTRL_4I -- requirements
Module: nem_ohmux_sel_ctrl_4i

Interface
REQ-001: The block SHALL have parameter T_RELEASE, default 2: relay release wait in cycles (legal range 1..255).
REQ-002: The block SHALL have parameter T_SETTLE, default 3: relay contact settle wait in cycles (legal range 1..255).
REQ-003: Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004: Port RST, input, 1 bit: synchronous, active-high reset.
REQ-005: Port REQ_VALID, input, 1 bit: a request is present.
REQ-006: Port REQ_EN, input, 1 bit: 1 selects input REQ_SEL; 0 requests all relays open.
REQ-007: Port REQ_SEL, input, 2 bits: binary index of the mux input to connect.
REQ-008: Port REQ_READY, output, 1 bit: the block can accept a request this cycle.
REQ-009: Ports S0, S1, S2, S3, output, 1 bit each: one-hot relay select drives for the 4-input one-hot NEM mux.
REQ-010: Port SEL_VALID, output, 1 bit: the selected path is settled and its output is usable.
REQ-011: Port CUR_SEL, output, 2 bits: index of the currently driven select; holds its last value while no select is driven.

Function
REQ-012: A request SHALL be accepted on a rising edge where REQ_VALID=1 and REQ_READY=1; REQ_SEL and REQ_EN SHALL be captured only at acceptance.
REQ-013: The FSM SHALL have states OFF, BREAK, MAKE and HOLD.
REQ-014: REQ_READY SHALL be 1 in OFF and HOLD and 0 in BREAK and MAKE; requests offered in BREAK or MAKE SHALL be ignored, not queued.
REQ-015: At most one of S0..S3 SHALL be 1 in any cycle.
REQ-016: A newly selected S SHALL never rise in the same cycle, or fewer than T_RELEASE cycles after, the previous S falls (break-before-make).
REQ-017: OFF, accept with REQ_EN=1 at edge t: S[REQ_SEL]=1 from t+1; state becomes MAKE; SEL_VALID=1 from t+1+T_SETTLE (state HOLD).
REQ-018: OFF, accept with REQ_EN=0: no state change and no output change.
REQ-019: HOLD, accept with REQ_EN=1 and REQ_SEL=CUR_SEL: no-op; S and SEL_VALID are unchanged.
REQ-020: HOLD, accept with REQ_EN=1 and REQ_SEL≠CUR_SEL at edge t:
- all S=0 and SEL_VALID=0 from t+1 (state BREAK);
- new S=1 from t+1+T_RELEASE (state MAKE);
- SEL_VALID=1 from t+1+T_RELEASE+T_SETTLE (state HOLD).
REQ-021: HOLD, accept with REQ_EN=0 at edge t: all S=0 and SEL_VALID=0 from t+1 (state BREAK); the state becomes OFF after T_RELEASE cycles.
REQ-022: The wait counter SHALL be 8 bits, loaded on entry to BREAK or MAKE with the corresponding parameter minus 1, decremented each cycle, and the state SHALL exit when the counter is 0.
REQ-023: CUR_SEL SHALL update in the cycle the new S rises.
REQ-024: SEL_VALID SHALL be 1 only in HOLD.

Reset
REQ-025: While RST=1 on an edge, the block SHALL set state OFF, S0..S3=0, SEL_VALID=0, REQ_READY=1 (valid the cycle after reset), CUR_SEL=0 and counter=0, regardless of REQ_VALID.
REQ-026: A reset during BREAK, MAKE or HOLD SHALL drop all S in the next cycle with no partial sequence resumed; RST SHALL take priority over a simultaneous accept.

Verification
REQ-027: Reset, then accept SEL=2 EN=1 at edge 0: S2=1 at cycle 1, SEL_VALID=1 at cycle 4, CUR_SEL=2.
REQ-028: From HOLD SEL=2, accept SEL=1 at edge t: S=0000 for cycles t+1..t+2, S1=1 at t+3, SEL_VALID=1 at t+6.
REQ-029: From HOLD SEL=3, accept SEL=3: S3 stays 1 and SEL_VALID stays 1 with no glitch.
REQ-030: From HOLD, accept EN=0: S=0000 at t+1, REQ_READY=0 at t+1..t+2, REQ_READY=1 and state OFF at t+3.
REQ-031: Assert RST during MAKE, with REQ_VALID held at 1 through reset: S=0000 and SEL_VALID=0 the next cycle, and no request is accepted while RST=1.
REQ-032: Random requests over 10k cycles with T_RELEASE=1 and T_SETTLE=1: an assertion checks one-hot-or-zero S and break-before-make on every cycle.

Source files
------------

// File: rtl/nem_ohmux_sel_ctrl_4i.sv
// Select controller for a 4-input one-hot NEM relay mux.
// Relays always break before they make. A released relay gets T_RELEASE
// cycles before any other relay closes. A closed relay gets T_SETTLE cycles
// before its path is reported usable on SEL_VALID.
module nem_ohmux_sel_ctrl_4i #(
    parameter int unsigned T_RELEASE = 2,   // relay release wait, 1..255
    parameter int unsigned T_SETTLE  = 3    // contact settle wait, 1..255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic       REQ_EN,
    input  logic [1:0] REQ_SEL,
    output logic       REQ_READY,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       SEL_VALID,
    output logic [1:0] CUR_SEL
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // The counter holds "cycles remaining minus one", so the load values are
    // the waits minus one and the state exits when the counter reads zero.
    localparam logic [7:0] REL_LOAD = 8'(T_RELEASE - 1);
    localparam logic [7:0] SET_LOAD = 8'(T_SETTLE - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] s_q;          // relay drives, bit i = S<i>
    logic       sel_valid_q;
    logic       ready_q;
    logic [1:0] cur_sel_q;
    logic [1:0] tgt_sel_q;    // selection waiting for its relay to close
    logic       tgt_en_q;     // 0: the pending request only opens the relays

    logic       accept;
    logic [3:0] req_onehot;
    logic [3:0] tgt_onehot;

    assign accept = REQ_VALID & ready_q;

    // Binary-to-one-hot decode of the request and pending-target indices.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign req_onehot[gi] = (REQ_SEL   == 2'(gi));
        assign tgt_onehot[gi] = (tgt_sel_q == 2'(gi));
    end

    // Sequencer: state, wait counter and every output are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_OFF;
            cnt_q       <= 8'd0;
            s_q         <= 4'b0000;
            sel_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            cur_sel_q   <= 2'd0;
            tgt_sel_q   <= 2'd0;
            tgt_en_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Nothing is closed, so the new relay may close at once.
                    // A request to open everything changes nothing.
                    if (accept && REQ_EN) begin
                        s_q       <= req_onehot;
                        cur_sel_q <= REQ_SEL;
                        tgt_sel_q <= REQ_SEL;
                        tgt_en_q  <= 1'b1;
                        cnt_q     <= SET_LOAD;
                        ready_q   <= 1'b0;
                        state_q   <= ST_MAKE;
                    end
                end
                ST_HOLD: begin
                    // Re-selecting the closed path is a no-op. Any other
                    // request opens the current relay first.
                    if (accept && !(REQ_EN && (REQ_SEL == cur_sel_q))) begin
                        s_q         <= 4'b0000;
                        sel_valid_q <= 1'b0;
                        tgt_sel_q   <= REQ_SEL;
                        tgt_en_q    <= REQ_EN;
                        cnt_q       <= REL_LOAD;
                        ready_q     <= 1'b0;
                        state_q     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == 8'd0) begin
                        if (tgt_en_q) begin
                            s_q       <= tgt_onehot;
                            cur_sel_q <= tgt_sel_q;
                            cnt_q     <= SET_LOAD;
                            state_q   <= ST_MAKE;
                        end else begin
                            ready_q   <= 1'b1;
                            state_q   <= ST_OFF;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_MAKE: begin
                    if (cnt_q == 8'd0) begin
                        sel_valid_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_OFF;
                    s_q         <= 4'b0000;
                    sel_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    cnt_q       <= 8'd0;
                end
            endcase
        end
    end

    assign S0        = s_q[0];
    assign S1        = s_q[1];
    assign S2        = s_q[2];
    assign S3        = s_q[3];
    assign SEL_VALID = sel_valid_q;
    assign REQ_READY = ready_q;
    assign CUR_SEL   = cur_sel_q;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl_4i.sv
// Bench for nem_ohmux_sel_ctrl_4i. It has a directed vector table and
// hand-written latency sequences for the default-parameter instance. It also
// runs a random soak on a second instance built with T_RELEASE=1 and
// T_SETTLE=1.
module tb_nem_ohmux_sel_ctrl_4i;

    localparam int R_REL = 1;
    localparam int R_SET = 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // default-parameter DUT
    logic       RST, REQ_VALID, REQ_EN;
    logic [1:0] REQ_SEL;
    logic       REQ_READY, S0, S1, S2, S3, SEL_VALID;
    logic [1:0] CUR_SEL;

    nem_ohmux_sel_ctrl_4i dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_EN(REQ_EN),
        .REQ_SEL(REQ_SEL), .REQ_READY(REQ_READY),
        .S0(S0), .S1(S1), .S2(S2), .S3(S3),
        .SEL_VALID(SEL_VALID), .CUR_SEL(CUR_SEL)
    );

    // fast-timing DUT for the random soak
    logic       r_rst, r_valid, r_en;
    logic [1:0] r_sel;
    logic       r_ready, r_s0, r_s1, r_s2, r_s3, r_sv;
    logic [1:0] r_cur;

    nem_ohmux_sel_ctrl_4i #(.T_RELEASE(R_REL), .T_SETTLE(R_SET)) dut_r (
        .CLK(CLK), .RST(r_rst), .REQ_VALID(r_valid), .REQ_EN(r_en),
        .REQ_SEL(r_sel), .REQ_READY(r_ready),
        .S0(r_s0), .S1(r_s1), .S2(r_s2), .S3(r_s3),
        .SEL_VALID(r_sv), .CUR_SEL(r_cur)
    );

    typedef struct {
        bit       rst;
        bit       valid;
        bit       en;
        bit [1:0] sel;
        bit [3:0] exp_s;    // {S3,S2,S1,S0}
        bit       exp_sv;
        bit       exp_rdy;
        bit [1:0] exp_cur;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(bit rst, bit v, bit en, bit [1:0] sel,
                                bit [3:0] s, bit sv, bit rdy, bit [1:0] cur);
        vec_t r;
        r.rst = rst; r.valid = v; r.en = en; r.sel = sel;
        r.exp_s = s; r.exp_sv = sv; r.exp_rdy = rdy; r.exp_cur = cur;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] svec();
        return {S3, S2, S1, S0};
    endfunction

    initial begin
        int sv_at, s3_at, zero_ok;
        logic [3:0] rs, prev_rs;
        int fall_cyc;
        bit have_fall;

        RST = 1'b1; REQ_VALID = 1'b0; REQ_EN = 1'b0; REQ_SEL = 2'd0;
        r_rst = 1'b1; r_valid = 1'b0; r_en = 1'b0; r_sel = 2'd0;

        // Each row: inputs applied before an edge, outputs expected after it.
        //            rst v  en sel   S        SV RDY CUR
        vecs[0]  = mk(1, 1, 1, 3, 4'b0000, 0, 1, 0); // reset beats valid
        vecs[1]  = mk(1, 0, 0, 0, 4'b0000, 0, 1, 0);
        vecs[2]  = mk(0, 1, 0, 1, 4'b0000, 0, 1, 0); // OFF, EN=0: nothing
        vecs[3]  = mk(0, 1, 1, 2, 4'b0100, 0, 0, 2); // OFF -> MAKE sel 2
        vecs[4]  = mk(0, 1, 1, 0, 4'b0100, 0, 0, 2); // ignored in MAKE
        vecs[5]  = mk(0, 0, 0, 0, 4'b0100, 0, 0, 2);
        vecs[6]  = mk(0, 0, 0, 0, 4'b0100, 1, 1, 2); // HOLD at cycle 4
        vecs[7]  = mk(0, 1, 1, 2, 4'b0100, 1, 1, 2); // same sel: no-op
        vecs[8]  = mk(0, 1, 1, 1, 4'b0000, 0, 0, 2); // switch -> BREAK
        vecs[9]  = mk(0, 1, 1, 3, 4'b0000, 0, 0, 2); // ignored in BREAK
        vecs[10] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1); // S1 at t+3
        vecs[11] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1);
        vecs[12] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 4'b0010, 1, 1, 1); // valid at t+6
        vecs[14] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1); // EN=0 from HOLD
        vecs[15] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 1); // OFF at t+3, CUR holds
        vecs[17] = mk(0, 1, 1, 3, 4'b1000, 0, 0, 3);
        vecs[18] = mk(0, 0, 0, 0, 4'b1000, 0, 0, 3);
        vecs[19] = mk(0, 0, 0, 0, 4'b1000, 0, 0, 3);
        vecs[20] = mk(0, 0, 0, 0, 4'b1000, 1, 1, 3);
        vecs[21] = mk(0, 1, 1, 3, 4'b1000, 1, 1, 3); // same sel, no glitch
        vecs[22] = mk(0, 1, 1, 0, 4'b0000, 0, 0, 3); // switch to 0
        vecs[23] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 3);
        vecs[24] = mk(0, 0, 0, 0, 4'b0001, 0, 0, 0); // MAKE sel 0
        vecs[25] = mk(1, 1, 1, 2, 4'b0000, 0, 1, 0); // reset during MAKE
        vecs[26] = mk(1, 1, 1, 2, 4'b0000, 0, 1, 0); // still no accept
        vecs[27] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0);
        vecs[28] = mk(0, 1, 1, 1, 4'b0010, 0, 0, 1);
        vecs[29] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1);
        vecs[30] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1);
        vecs[31] = mk(0, 0, 0, 0, 4'b0010, 1, 1, 1);
        vecs[32] = mk(1, 1, 1, 2, 4'b0000, 0, 1, 0); // reset during HOLD

        for (int i = 0; i < NVEC; i++) begin
            RST = vecs[i].rst; REQ_VALID = vecs[i].valid;
            REQ_EN = vecs[i].en; REQ_SEL = vecs[i].sel;
            @(posedge CLK); #1;
            $display("row %0d: rst=%0b valid=%0b en=%0b sel=%0d -> S=%b SV=%0b RDY=%0b CUR=%0d",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].en, vecs[i].sel,
                     svec(), SEL_VALID, REQ_READY, CUR_SEL);
            chk($sformatf("row%0d S", i),         int'(svec()),    int'(vecs[i].exp_s));
            chk($sformatf("row%0d SEL_VALID", i), int'(SEL_VALID), int'(vecs[i].exp_sv));
            chk($sformatf("row%0d REQ_READY", i), int'(REQ_READY), int'(vecs[i].exp_rdy));
            chk($sformatf("row%0d CUR_SEL", i),   int'(CUR_SEL),   int'(vecs[i].exp_cur));
        end

        // Sequence: from OFF, accept sel 0 and time SEL_VALID.
        RST = 1'b0; REQ_VALID = 1'b1; REQ_EN = 1'b1; REQ_SEL = 2'd0;
        sv_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            REQ_VALID = 1'b0;
            if (SEL_VALID) begin sv_at = c; break; end
        end
        $display("seq off->0: SEL_VALID after %0d cycles", sv_at);
        chk("seq off->0 valid latency", sv_at, 4);

        // Sequence: from HOLD sel 0, switch to sel 3; time S3 and SEL_VALID,
        // and require all relays open until S3 closes.
        REQ_VALID = 1'b1; REQ_EN = 1'b1; REQ_SEL = 2'd3;
        sv_at = 0; s3_at = 0; zero_ok = 1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            REQ_VALID = 1'b0;
            if (s3_at == 0 && svec() != 4'b0000 && !S3) zero_ok = 0;
            if (S3 && s3_at == 0) s3_at = c;
            if (SEL_VALID) begin sv_at = c; break; end
        end
        $display("seq 0->3: S3 after %0d, SEL_VALID after %0d cycles", s3_at, sv_at);
        chk("seq 0->3 S3 latency", s3_at, 3);
        chk("seq 0->3 valid latency", sv_at, 6);
        chk("seq 0->3 break gap all-open", zero_ok, 1);
        chk("seq 0->3 CUR_SEL", int'(CUR_SEL), 3);

        // Random soak on the fast-timing instance.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        r_rst = 1'b0;
        prev_rs = 4'b0000; fall_cyc = 0; have_fall = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_valid = ($urandom_range(0, 3) == 0);
            r_en    = ($urandom_range(0, 4) != 0);
            r_sel   = 2'($urandom_range(0, 3));
            @(posedge CLK); #1;
            rs = {r_s3, r_s2, r_s1, r_s0};
            checks++;
            if (!$onehot0(rs)) begin
                errors++;
                $display("FAIL rand onehot cyc%0d: S=%b, required one-hot or zero", cyc, rs);
            end
            checks++;
            if (prev_rs != 4'b0000 && rs != 4'b0000 && rs != prev_rs) begin
                errors++;
                $display("FAIL rand break-before-make cyc%0d: S %b -> %b, required an open gap", cyc, prev_rs, rs);
            end
            if (prev_rs != 4'b0000 && rs == 4'b0000) begin
                fall_cyc = cyc; have_fall = 1'b1;
            end
            if (prev_rs == 4'b0000 && rs != 4'b0000 && have_fall) begin
                checks++;
                if (cyc - fall_cyc < R_REL) begin
                    errors++;
                    $display("FAIL rand release gap cyc%0d: %0d cycles, required >= %0d", cyc, cyc - fall_cyc, R_REL);
                end
            end
            checks++;
            if (r_sv && rs == 4'b0000) begin
                errors++;
                $display("FAIL rand SEL_VALID cyc%0d: valid=1 with S=%b, required a closed relay", cyc, rs);
            end
            prev_rs = rs;
        end
        $display("random soak: 10000 cycles with T_RELEASE=%0d T_SETTLE=%0d", R_REL, R_SET);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
